// File: rtl/snn_stim_pkg.sv
// ============================================================================
// snn_stim_pkg : shared state encoding and NVM row layout for the stim driver
// Revision     : 1.0
// ============================================================================
`default_nettype none

package snn_stim_pkg;

    localparam int MEM_DW   = 32;
    localparam int CONN_LSB = 0;
    localparam int STIM_LSB = 16;
    localparam int STIM_W   = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        REQ   = 3'd2,
        APPLY = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/axon_prio_enc.sv
// ============================================================================
// axon_prio_enc : combinational lowest-set-bit encoder over the pending axons
// Revision      : 1.0
// ============================================================================
`default_nettype none

module axon_prio_enc
    import snn_stim_pkg::*;
#(
    parameter int NUM_AXON = 32,
    parameter int AXON_AW  = 5
) (
    input  logic [NUM_AXON-1:0] vec_i,
    output logic [AXON_AW-1:0]  idx_o,
    output logic                any_o
);

    // Descending walk so the lowest set bit is the last assignment to win.
    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        for (int i = NUM_AXON - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = i[AXON_AW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/synapse_stim_driver.sv
// ============================================================================
// synapse_stim_driver : walks active axons, fetches synapse rows from NVM and
//                       strobes them into the neuron accumulator.
// Optional build macro: SYNAPSE_STIM_SKIP_ZERO_EN (skip rows with empty mask)
// Revision            : 1.0
// ============================================================================
`default_nettype none

module synapse_stim_driver
    import snn_stim_pkg::*;
#(
    parameter int NUM_AXON   = 32,
    parameter int NUM_NEURON = 16,
    parameter int AXON_AW    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_AXON-1:0]   spike_in,
    input  logic                  spike_in_last,
    input  logic                  spike_in_valid,
    output logic                  spike_in_ready,
    output logic                  mem_req,
    output logic [AXON_AW-1:0]    mem_addr,
    input  logic                  mem_ack,
    input  logic [MEM_DW-1:0]     mem_rdata,
    output logic [STIM_W-1:0]     stimuli,
    output logic [NUM_NEURON-1:0] connection,
    output logic                  enable,
    output logic                  picture_done,
    output logic                  busy
);

    state_e                 state_q, state_d;
    logic [NUM_AXON-1:0]    pending_q, pending_d;
    logic                   last_q, last_d;
    logic [AXON_AW-1:0]     addr_q, addr_d;
    logic [STIM_W-1:0]      stim_q, stim_d;
    logic [NUM_NEURON-1:0]  conn_q, conn_d;

    logic [AXON_AW-1:0]     w_idx;
    logic                   w_any;
    logic [NUM_NEURON-1:0]  w_row_conn;
    logic [STIM_W-1:0]      w_row_stim;

    assign w_row_conn = mem_rdata[CONN_LSB +: NUM_NEURON];
    assign w_row_stim = mem_rdata[STIM_LSB +: STIM_W];

    axon_prio_enc #(
        .NUM_AXON (NUM_AXON),
        .AXON_AW  (AXON_AW)
    ) u_prio_enc (
        .vec_i (pending_q),
        .idx_o (w_idx),
        .any_o (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            last_q    <= 1'b0;
            addr_q    <= '0;
            stim_q    <= '0;
            conn_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            stim_q    <= stim_d;
            conn_q    <= conn_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        last_d    = last_q;
        addr_d    = addr_q;
        stim_d    = stim_q;
        conn_d    = conn_q;
        case (state_q)
            IDLE: begin
                if (spike_in_valid) begin
                    pending_d = spike_in;
                    last_d    = spike_in_last;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (w_any) begin
                    addr_d  = w_idx;
                    state_d = REQ;
                end else if (last_q) begin
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    pending_d[addr_q] = 1'b0;
`ifdef SYNAPSE_STIM_SKIP_ZERO_EN
                    if (w_row_conn == '0) begin
                        state_d = SCAN;
                    end else begin
                        stim_d  = w_row_stim;
                        conn_d  = w_row_conn;
                        state_d = APPLY;
                    end
`else
                    stim_d  = w_row_stim;
                    conn_d  = w_row_conn;
                    state_d = APPLY;
`endif
                end
            end
            APPLY: begin
                state_d = SCAN;
            end
            DONE: begin
                last_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready is qualified by rst_n so every output reads 0 while reset is held.
    assign spike_in_ready = (state_q == IDLE) && rst_n;
    assign mem_req        = (state_q == REQ);
    assign mem_addr       = addr_q;
    assign enable         = (state_q == APPLY);
    assign picture_done   = (state_q == DONE);
    assign busy           = (state_q != IDLE);
    assign stimuli        = stim_q;
    assign connection     = conn_q;

endmodule

`default_nettype wire

// File: tb/tb_synapse_stim_driver.sv
// ============================================================================
// tb_synapse_stim_driver : scoreboard bench for synapse_stim_driver
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_synapse_stim_driver;

    typedef struct {
        bit          done;
        logic [15:0] stim;
        logic [15:0] conn;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] spike_in = '0;
    logic        spike_in_last = 1'b0;
    logic        spike_in_valid = 1'b0;
    logic        spike_in_ready;
    logic        mem_req;
    logic [4:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [15:0] stimuli;
    logic [15:0] connection;
    logic        enable;
    logic        picture_done;
    logic        busy;

    int          cmp_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          last_en = -100;
    int          req_cycles = 0;
    int          ack_delay = 0;
    bit          spur = 1'b0;
    logic [31:0] rows [32];
    ev_t         exp_q [$];

    synapse_stim_driver #(
        .NUM_AXON   (32),
        .NUM_NEURON (16),
        .AXON_AW    (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spike_in       (spike_in),
        .spike_in_last  (spike_in_last),
        .spike_in_valid (spike_in_valid),
        .spike_in_ready (spike_in_ready),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .stimuli        (stimuli),
        .connection     (connection),
        .enable         (enable),
        .picture_done   (picture_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_en(input logic [15:0] s, input logic [15:0] c);
        ev_t e;
        e.done = 1'b0; e.stim = s; e.conn = c;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        ev_t e;
        e.done = 1'b1; e.stim = '0; e.conn = '0;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per enable or picture_done strobe.
    always @(negedge clk) begin
        ev_t e;
        if (mem_req) req_cycles++;
        if (enable || picture_done) begin
            chk("overlap", {31'd0, enable & picture_done}, 32'd0);
            if (exp_q.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL unexpected_output: enable=%0b done=%0b stim=%h conn=%h, none expected",
                         enable, picture_done, stimuli, connection);
            end else begin
                e = exp_q.pop_front();
                chk("kind_done", {31'd0, picture_done}, {31'd0, e.done});
                if (!e.done) begin
                    chk("stimuli", {16'd0, stimuli}, {16'd0, e.stim});
                    chk("connection", {16'd0, connection}, {16'd0, e.conn});
                end else begin
                    chk("done_gap_ge2", {31'd0, (cyc - last_en) >= 2}, 32'd1);
                end
            end
            if (enable) last_en = cyc;
        end
    end

    // NVM model: acks after ack_delay extra cycles, checks req/addr hold meanwhile.
    initial begin
        logic [4:0] a;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (spur) begin
                mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; spur = 1'b0;
                @(negedge clk);
                mem_ack = 1'b0;
            end else if (mem_req && rst_n) begin
                a = mem_addr;
                aborted = 1'b0;
                for (int i = 0; i < ack_delay; i++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    chk("req_held", {31'd0, mem_req}, 32'd1);
                    chk("addr_held", {27'd0, mem_addr}, {27'd0, a});
                end
                if (!aborted) begin
                    mem_ack = 1'b1; mem_rdata = rows[a];
                    @(negedge clk);
                    mem_ack = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] v, input logic lst);
        int t = 0;
        while (!spike_in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("ready_timeout", 32'd1, 32'd0);
        spike_in = v; spike_in_last = lst; spike_in_valid = 1'b1;
        @(negedge clk);
        spike_in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("drain_timeout", 32'd1, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int r0;
        for (int i = 0; i < 32; i++) rows[i] = {16'(i + 1), 16'h0001};

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, spike_in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_outs", {enable, picture_done, stimuli, connection[13:0]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, spike_in_ready}, 32'd1);

        // Two active axons, final timestep
        rows[0] = 32'h0010_0003; rows[2] = 32'hFFF0_0001;
        ack_delay = 1;
        r0 = req_cycles;
        push_en(16'h0010, 16'h0003);
        push_en(16'hFFF0, 16'h0001);
        push_done();
        send(32'h0000_0005, 1'b1);
        drain();
        chk("t1_req_cycles", 32'(req_cycles - r0), 32'd4);
        chk("t1_hold_stim", {16'd0, stimuli}, 32'h0000_FFF0);
        chk("t1_hold_conn", {16'd0, connection}, 32'h0000_0001);

        // Empty vector, not last
        r0 = req_cycles;
        send(32'h0, 1'b0);
        chk("t2_ready_low", {31'd0, spike_in_ready}, 32'd0);
        @(negedge clk);
        chk("t2_ready_back", {31'd0, spike_in_ready}, 32'd1);
        drain();
        chk("t2_no_req", 32'(req_cycles - r0), 32'd0);

        // Empty vector, last
        r0 = req_cycles;
        push_done();
        send(32'h0, 1'b1);
        chk("t3_done_early", {31'd0, picture_done}, 32'd0);
        @(negedge clk);
        chk("t3_done_at2", {31'd0, picture_done}, 32'd1);
        drain();
        chk("t3_no_req", 32'(req_cycles - r0), 32'd0);

        // Slow ack, spurious ack in IDLE, top axon index
        rows[0] = 32'h8000_FFFF; rows[31] = 32'h7FFF_8000;
        ack_delay = 5;
        r0 = req_cycles;
        spur = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_spur_ignored", {31'd0, busy}, 32'd0);
        push_en(16'h8000, 16'hFFFF);
        push_en(16'h7FFF, 16'h8000);
        send(32'h8000_0001, 1'b0);
        drain();
        chk("t4_req_cycles", 32'(req_cycles - r0), 32'd12);

        // Asynchronous reset in REQ
        ack_delay = 3;
        send(32'hFFFF_FFFF, 1'b1);
        begin
            int t = 0;
            while (!mem_req && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t >= 20) chk("t5_req_timeout", 32'd1, 32'd0);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_req", {31'd0, mem_req}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_ready", {31'd0, spike_in_ready}, 32'd0);
        chk("t5_rst_addr", {27'd0, mem_addr}, 32'd0);
        chk("t5_rst_data", {stimuli, connection}, 32'd0);
        chk("t5_rst_strobes", {30'd0, enable, picture_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r0 = req_cycles;
        @(negedge clk);
        chk("t5_ready_after", {31'd0, spike_in_ready}, 32'd1);
        repeat (10) @(negedge clk);
        chk("t5_no_stale_req", 32'(req_cycles - r0), 32'd0);

        // Row with empty connection mask
        rows[1] = 32'h1234_0000;
        ack_delay = 0;
`ifndef SYNAPSE_STIM_SKIP_ZERO_EN
        push_en(16'h1234, 16'h0000);
`endif
        send(32'h0000_0002, 1'b0);
        drain();
`ifdef SYNAPSE_STIM_SKIP_ZERO_EN
        chk("t6_hold_stim", {16'd0, stimuli}, 32'h0000_0000);
`else
        chk("t6_hold_stim", {16'd0, stimuli}, 32'h0000_1234);
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
